frame_addr_gen: RTL and testbench
=================================

// Module: frame_addr_gen
// PURPOSE
//  Maps the display raster position (hcount_in, vcount_in) to a read address in a frame buffer of
//  SRC_W x SRC_H pixels. Supports power-of-two upscale, window offset, horizontal mirror and
//  out-of-window flagging. Configuration is frame-synchronous.
//  Fixed-latency, valid-tagged pipeline between the raster timing generator and the frame-buffer BRAM.
// PARAMETERS
//  SRC_W    240  source frame width in pixels
//  SRC_H    320  source frame height in pixels
//  HC_W     11   hcount_in width
//  VC_W     10   vcount_in width
//  ADDR_W   17   pixel_addr_out width; must satisfy 2**ADDR_W >= SRC_W*SRC_H
// PORTS
//  clk_in          in   1       system clock; one clock domain only
//  rst_in          in   1       asynchronous reset, active-high
//  valid_in        in   1       hcount_in/vcount_in are valid this cycle
//  hcount_in       in   HC_W    raster x
//  vcount_in       in   VC_W    raster y
//  frame_start_in  in   1       1-cycle pulse: load new config (normally coincides with raster (0,0))
//  scale_in        in   2       00 x1, 01 x2, 10 x4, 11 x8
//  mirror_in       in   1       horizontal mirror
//  vflip_in        in   1       vertical flip; only used under FRAME_ADDR_VFLIP_EN
//  x_off_in        in   HC_W    window left edge, raster coords
//  y_off_in        in   VC_W    window top edge, raster coords
//  valid_out       out  1       valid_in delayed 3 cycles
//  in_window_out   out  1       pixel lies inside the scaled source window
//  pixel_addr_out  out  ADDR_W  src_x + SRC_W*src_y; 0 when !in_window_out
// BEHAVIOUR
//  Reset: all outputs 0. Pipeline valid bits cleared. Shadow config = scale x1, no mirror/flip, offsets 0.
//  Shadow config: on a cycle with frame_start_in=1, the *_in config ports are latched.
//   - The pixel presented in that same cycle already uses the new config (stage-1 bypass mux).
//   - Config ports are ignored on all other cycles. Mid-frame changes have no effect.
//  Pipeline, latency 3; one pixel per cycle, no stall.
//  Invalid beats still flow through but produce valid_out=0, in_window_out=0, addr 0.
//   S1: rel_x = hcount - x_off, rel_y = vcount - y_off, computed at signed HC_W+1 / VC_W+1 bits.
//       Latch valid and the effective config.
//   S2: sh = scale code (0..3). src_x = rel_x >>> sh; src_y = rel_y >>> sh.
//       in_window = rel_x>=0 && rel_y>=0 && src_x<SRC_W && src_y<SRC_H.
//       mirror: src_x = SRC_W-1-src_x, applied after the window test
//       (raster x_off -> SRC_W-1; last in-window column -> 0).
//   S3: pixel_addr_out = src_x + SRC_W*src_y at ADDR_W bits. Constant multiply; no divider.
//       valid_out and in_window_out are registered in the same stage.
//  Boundaries:
//   - rel negative (left of or above the window) -> in_window 0.
//   - Exactly SRC_W<<sh columns and SRC_H<<sh rows are in-window.
//   - Raster larger than the window is not an error; those pixels are just out-of-window.
//   - rst_in asserted mid-frame: outputs drop to 0 asynchronously; config returns to defaults.
//     First valid_out comes 3 cycles after the first post-reset valid_in.
// CONFIGURATION
//  FRAME_ADDR_VFLIP_EN defined:
//   - vflip_in is latched with the config. When set, S2 applies src_y = SRC_H-1-src_y after the window test.
//  FRAME_ADDR_VFLIP_EN undefined:
//   - vflip_in is unconnected internally; no flip logic is generated. Port kept for pin compatibility.
// STRUCTURE
//  Package frame_addr_pkg:
//   - scale_t enum (SCALE_X1..SCALE_X8 = 2'b00..2'b11)
//   - cfg_t struct {scale, mirror, vflip, x_off, y_off}
//   - DEFAULT_CFG constant
//  Single module, no sub-modules; the S1-S3 registers are explicit always_ff blocks.
// TESTING
//  1 Reset, scale x1, offsets 0, no mirror; h=5,v=2 -> 3 cycles later addr=485, in_window=1, valid=1.
//  2 Scale x2: h=479,v=639 -> addr 76799.
//    Scale x2: h=480,v=0 -> in_window=0, addr=0.
//  3 Mirror, x1: h=0 -> src_x 239, addr 239.
//    Mirror, x1: h=239 -> addr 0.
//    Mirror, x4, x_off=100: h=100 -> addr 239.
//  4 frame_start_in with scale=01 on the (0,0) beat -> that beat already uses x2.
//    Changing scale_in mid-frame without frame_start_in -> output unchanged.
//  5 x_off=50,y_off=10: h=49 or v=9 -> in_window 0.
//    h=50,v=10 -> addr 0.
//    valid_in=0 bubbles -> valid_out=0 exactly 3 cycles later.
//  6 Assert rst_in mid-stream -> outputs 0 immediately, config back to x1.
//    With FRAME_ADDR_VFLIP_EN and vflip, x1: v=0,h=0 -> addr 76560.

Source files
------------

// File: rtl/frame_addr_gen_pkg.sv
// Shared types for the frame-buffer address generator: scale codes, the
// frame-synchronous configuration record and its power-on default.
package frame_addr_pkg;

  localparam int CFG_HC_W = 11;
  localparam int CFG_VC_W = 10;

  typedef enum logic [1:0] {
    SCALE_X1 = 2'b00,
    SCALE_X2 = 2'b01,
    SCALE_X4 = 2'b10,
    SCALE_X8 = 2'b11
  } scale_t;

  typedef struct packed {
    scale_t                scale;
    logic                  mirror;
    logic                  vflip;
    logic [CFG_HC_W-1:0]   x_off;
    logic [CFG_VC_W-1:0]   y_off;
  } cfg_t;

  localparam cfg_t DEFAULT_CFG = '{
    scale:  SCALE_X1,
    mirror: 1'b0,
    vflip:  1'b0,
    x_off:  {CFG_HC_W{1'b0}},
    y_off:  {CFG_VC_W{1'b0}}
  };

endpackage

// File: rtl/frame_addr_gen.sv
// Raster (h,v) -> frame-buffer read address, 3-stage valid-tagged pipeline.
// Optional vertical flip is built only when FRAME_ADDR_VFLIP_EN is defined.
module frame_addr_gen
  import frame_addr_pkg::*;
#(
  parameter int SRC_W  = 240,
  parameter int SRC_H  = 320,
  parameter int HC_W   = 11,
  parameter int VC_W   = 10,
  parameter int ADDR_W = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              valid_in,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              frame_start_in,
  input  logic [1:0]        scale_in,
  input  logic              mirror_in,
  input  logic              vflip_in,
  input  logic [HC_W-1:0]   x_off_in,
  input  logic [VC_W-1:0]   y_off_in,
  output logic              valid_out,
  output logic              in_window_out,
  output logic [ADDR_W-1:0] pixel_addr_out
);

  localparam int XW  = HC_W + 1;
  localparam int YW  = VC_W + 1;
  localparam int SXW = $clog2(SRC_W);
  localparam int SYW = $clog2(SRC_H);

  cfg_t r_cfg;
  cfg_t w_cfg_in;
  cfg_t w_cfg_eff;

  always_comb begin
    w_cfg_in        = DEFAULT_CFG;
    w_cfg_in.scale  = scale_t'(scale_in);
    w_cfg_in.mirror = mirror_in;
    w_cfg_in.x_off  = CFG_HC_W'(x_off_in);
    w_cfg_in.y_off  = CFG_VC_W'(y_off_in);
`ifdef FRAME_ADDR_VFLIP_EN
    w_cfg_in.vflip  = vflip_in;
`else
    w_cfg_in.vflip  = 1'b0;
`endif
  end

  // The frame_start beat itself must already see the new configuration.
  assign w_cfg_eff = frame_start_in ? w_cfg_in : r_cfg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cfg <= DEFAULT_CFG;
    end else if (frame_start_in) begin
      r_cfg <= w_cfg_in;
    end
  end

  // ---------------- S1: window-relative coordinates
  logic                 r1_valid;
  logic signed [XW-1:0] r1_rel_x;
  logic signed [YW-1:0] r1_rel_y;
  logic [1:0]           r1_scale;
  logic                 r1_mirror;
  logic signed [XW-1:0] w1_rel_x;
  logic signed [YW-1:0] w1_rel_y;

  assign w1_rel_x = $signed({1'b0, hcount_in}) - $signed({1'b0, HC_W'(w_cfg_eff.x_off)});
  assign w1_rel_y = $signed({1'b0, vcount_in}) - $signed({1'b0, VC_W'(w_cfg_eff.y_off)});

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r1_valid  <= 1'b0;
      r1_rel_x  <= '0;
      r1_rel_y  <= '0;
      r1_scale  <= 2'b00;
      r1_mirror <= 1'b0;
    end else begin
      r1_valid  <= valid_in;
      r1_rel_x  <= w1_rel_x;
      r1_rel_y  <= w1_rel_y;
      r1_scale  <= w_cfg_eff.scale;
      r1_mirror <= w_cfg_eff.mirror;
    end
  end

`ifdef FRAME_ADDR_VFLIP_EN
  logic r1_vflip;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r1_vflip <= 1'b0;
    end else begin
      r1_vflip <= w_cfg_eff.vflip;
    end
  end
`else
  logic w_unused_vflip;
  assign w_unused_vflip = vflip_in ^ w_cfg_eff.vflip;
`endif

  // ---------------- S2: downscale to source coordinates, window test
  logic signed [XW-1:0] w2_sx_full;
  logic signed [YW-1:0] w2_sy_full;
  logic                 w2_in;
  logic [SXW-1:0]       w2_sx;
  logic [SYW-1:0]       w2_sy;
  logic                 r2_valid;
  logic                 r2_in;
  logic [SXW-1:0]       r2_sx;
  logic [SYW-1:0]       r2_sy;

  always_comb begin
    w2_sx_full = r1_rel_x >>> r1_scale;
    w2_sy_full = r1_rel_y >>> r1_scale;
    w2_in      = r1_valid && !r1_rel_x[XW-1] && !r1_rel_y[YW-1] &&
                 (w2_sx_full < $signed(XW'(SRC_W))) &&
                 (w2_sy_full < $signed(YW'(SRC_H)));
    w2_sx      = w2_sx_full[SXW-1:0];
    w2_sy      = w2_sy_full[SYW-1:0];
    if (r1_mirror) begin
      w2_sx = SXW'(SRC_W - 1) - w2_sx;
    end else begin
      w2_sx = w2_sx;
    end
`ifdef FRAME_ADDR_VFLIP_EN
    if (r1_vflip) begin
      w2_sy = SYW'(SRC_H - 1) - w2_sy;
    end else begin
      w2_sy = w2_sy;
    end
`endif
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r2_valid <= 1'b0;
      r2_in    <= 1'b0;
      r2_sx    <= '0;
      r2_sy    <= '0;
    end else begin
      r2_valid <= r1_valid;
      r2_in    <= w2_in;
      r2_sx    <= w2_in ? w2_sx : '0;
      r2_sy    <= w2_in ? w2_sy : '0;
    end
  end

  // ---------------- S3: linear address (constant multiply)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_out      <= 1'b0;
      in_window_out  <= 1'b0;
      pixel_addr_out <= '0;
    end else begin
      valid_out      <= r2_valid;
      in_window_out  <= r2_in;
      pixel_addr_out <= ADDR_W'(r2_sx) + ADDR_W'(r2_sy) * ADDR_W'(SRC_W);
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench for frame_addr_gen: vector table, reset/corner
// sequences and a randomised sweep against a division-based model.
module tb_frame_addr_gen;

`ifdef FRAME_ADDR_VFLIP_EN
  localparam bit VF_EN = 1'b1;
`else
  localparam bit VF_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_start_in;
  logic [1:0]  scale_in;
  logic        mirror_in;
  logic        vflip_in;
  logic [10:0] x_off_in;
  logic [9:0]  y_off_in;
  logic        valid_out;
  logic        in_window_out;
  logic [16:0] pixel_addr_out;

  always #5 clk_in = ~clk_in;

  frame_addr_gen dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .valid_in       (valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .frame_start_in (frame_start_in),
    .scale_in       (scale_in),
    .mirror_in      (mirror_in),
    .vflip_in       (vflip_in),
    .x_off_in       (x_off_in),
    .y_off_in       (y_off_in),
    .valid_out      (valid_out),
    .in_window_out  (in_window_out),
    .pixel_addr_out (pixel_addr_out)
  );

  typedef struct {
    int fs; int sc; int mi; int vf; int xo; int yo;
    int vl; int h; int v; int ev; int ew; int ea;
  } vec_t;

  typedef struct {
    logic        v;
    logic        w;
    logic [16:0] a;
    int          id;
  } exp_t;

  vec_t tbl[20];
  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b w=%0b a=%0d, expected v=%0b w=%0b a=%0d",
               name, act[18], act[17], act[16:0], exp[18], exp[17], exp[16:0]);
    end
  endtask

  // One beat: drive, push expectation, clock, compare whatever left the pipe.
  task automatic beat(input int fs, input int sc, input int mi, input int vf,
                      input int xo, input int yo, input int vl, input int h,
                      input int v, input exp_t e);
    exp_t got;
    frame_start_in = fs[0];
    scale_in       = sc[1:0];
    mirror_in      = mi[0];
    vflip_in       = vf[0];
    x_off_in       = 11'(xo);
    y_off_in       = 10'(yo);
    valid_in       = vl[0];
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    q.push_back(e);
    @(posedge clk_in);
    #1;
    if (q.size() == 3) begin
      got = q.pop_front();
      check($sformatf("beat%0d", got.id), {valid_out, in_window_out, pixel_addr_out},
            {got.v, got.w, got.a});
    end else begin
      check("pipe_fill", {valid_out, in_window_out, pixel_addr_out}, 19'd0);
    end
  endtask

  function automatic exp_t model(input int h, input int v, input int s, input bit mi,
                                 input bit vf, input int xo, input int yo, input bit vl,
                                 input int id);
    exp_t e;
    int rx;
    int ry;
    e.v = vl; e.w = 1'b0; e.a = 17'd0; e.id = id;
    if (vl && h >= xo && v >= yo) begin
      rx = (h - xo) / (1 << s);
      ry = (v - yo) / (1 << s);
      if (rx < 240 && ry < 320) begin
        e.w = 1'b1;
        if (mi) rx = 239 - rx;
        if (vf && VF_EN) ry = 319 - ry;
        e.a = 17'(rx + 240 * ry);
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input int ev, input int ew, input int ea, input int id);
    exp_t e;
    e.v = ev[0]; e.w = ew[0]; e.a = 17'(ea); e.id = id;
    return e;
  endfunction

  initial begin
    int s, mi, xo, yo, h, v;
    tbl[0]  = '{1, 0, 0, 0,   0,  0, 1,    5,    2, 1, 1,   485};
    tbl[1]  = '{0, 0, 0, 0,   0,  0, 1,    0,    0, 1, 1,     0};
    tbl[2]  = '{1, 1, 0, 0,   0,  0, 1,    2,    2, 1, 1,   241};
    tbl[3]  = '{0, 0, 0, 0,   0,  0, 1,  479,  639, 1, 1, 76799};
    tbl[4]  = '{0, 3, 0, 0,   0,  0, 1,  480,    0, 1, 0,     0};
    tbl[5]  = '{0, 0, 0, 0,   0,  0, 0,    5,    2, 0, 0,     0};
    tbl[6]  = '{1, 0, 1, 0,   0,  0, 1,    0,    0, 1, 1,   239};
    tbl[7]  = '{0, 0, 0, 0,   0,  0, 1,  239,    0, 1, 1,     0};
    tbl[8]  = '{0, 0, 0, 0,   0,  0, 1,  240,    0, 1, 0,     0};
    tbl[9]  = '{1, 2, 1, 0, 100,  0, 1,  100,    0, 1, 1,   239};
    tbl[10] = '{0, 0, 0, 0,   0,  0, 1,   99,    0, 1, 0,     0};
    tbl[11] = '{0, 0, 0, 0,   0,  0, 1, 1059, 1023, 1, 1, 61200};
    tbl[12] = '{1, 0, 0, 0,  50, 10, 1,   49,   10, 1, 0,     0};
    tbl[13] = '{0, 0, 0, 0,   0,  0, 1,   50,    9, 1, 0,     0};
    tbl[14] = '{0, 0, 0, 0,   0,  0, 1,   50,   10, 1, 1,     0};
    tbl[15] = '{0, 0, 0, 0,   0,  0, 0,   50,   10, 0, 0,     0};
    tbl[16] = '{0, 0, 0, 0,   0,  0, 1,   51,   11, 1, 1,   241};
    tbl[17] = '{1, 3, 0, 0,   0,  0, 1, 1919, 1023, 1, 1, 30719};
    tbl[18] = '{0, 0, 0, 0,   0,  0, 1, 1920,    0, 1, 0,     0};
    tbl[19] = '{1, 0, 0, 1,   0,  0, 1,    0,    0, 1, 1, VF_EN ? 76560 : 0};

    rst_in = 1'b1; valid_in = 1'b0; hcount_in = 11'd0; vcount_in = 10'd0;
    frame_start_in = 1'b0; scale_in = 2'b00; mirror_in = 1'b0; vflip_in = 1'b0;
    x_off_in = 11'd0; y_off_in = 10'd0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_outputs", {valid_out, in_window_out, pixel_addr_out}, 19'd0);
    rst_in = 1'b0;

    for (int i = 0; i < 20; i++) begin
      beat(tbl[i].fs, tbl[i].sc, tbl[i].mi, tbl[i].vf, tbl[i].xo, tbl[i].yo,
           tbl[i].vl, tbl[i].h, tbl[i].v, mk(tbl[i].ev, tbl[i].ew, tbl[i].ea, i));
    end
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 100));
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 101));

    // Mid-stream asynchronous reset while x2 pixels are in flight.
    beat(1, 1, 0, 0, 0, 0, 1, 10, 10, mk(1, 1, 1205, 200));
    beat(0, 0, 0, 0, 0, 0, 1, 12, 10, mk(1, 1, 1206, 201));
    beat(0, 0, 0, 0, 0, 0, 1, 14, 10, mk(1, 1, 1207, 202));
    #3 rst_in = 1'b1;
    #1;
    check("async_reset", {valid_out, in_window_out, pixel_addr_out}, 19'd0);
    q.delete();
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    beat(0, 1, 0, 0, 0, 0, 1, 5, 2, mk(1, 1, 485, 300));
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 301));
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 302));
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 303));

    // Randomised frames checked against an independent division model.
    for (int f = 0; f < 4; f++) begin
      s  = int'($urandom_range(0, 3));
      mi = int'($urandom_range(0, 1));
      xo = int'($urandom_range(0, 300));
      yo = int'($urandom_range(0, 200));
      beat(1, s, mi, 1, xo, yo, 1, xo, yo, model(xo, yo, s, mi[0], 1'b1, xo, yo, 1'b1, 400 + f * 50));
      for (int k = 1; k < 30; k++) begin
        h = xo - 2 + int'($urandom_range(0, (240 << s) + 4));
        v = yo - 2 + int'($urandom_range(0, (320 << s) + 4));
        if (h < 0) h = 0;
        if (h > 2047) h = 2047;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        beat(0, 0, 0, 0, 0, 0, 1, h, v, model(h, v, s, mi[0], 1'b1, xo, yo, 1'b1, 400 + f * 50 + k));
      end
    end
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 900));
    beat(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 901));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
